uart_tx_core: RTL and testbench

Parametrised serial transmitter for the serial subsystem. It pops words from a first-word-fall-through TX FIFO and serialises each word as an asynchronous frame: start bit, 5–9 data bits LSB first, optional parity, 1 or 2 stop bits. Bit timing is derived from an external baud-rate-generator strobe with a configurable oversampling ratio. Beyond basic framing, the block supports mark/space parity, per-frame configuration latching, break generation, back-to-back frames with no idle gap, and busy/done status for the register/interrupt layer.

---
 rtl/uart_tx_core_if.sv | 28 ++
 rtl/uart_tx_core.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_core.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if
// TX FIFO handshake between the serial transmitter and its first-word-fall-through
// TX FIFO.
//   fifo_empty   : FIFO has no word to send
//   data         : FIFO head word, valid while fifo_empty is low
//   data_request : one-clk pop strobe from the transmitter
// Modports:
//   master : the transmitter, which pops the FIFO
//   slave  : the FIFO, which is popped
interface uart_tx_core_if #(
    parameter int DATA_W = 9
);
    logic              fifo_empty;
    logic [DATA_W-1:0] data;
    logic              data_request;

    modport master (
        input  fifo_empty,
        input  data,
        output data_request
    );

    modport slave (
        output fifo_empty,
        output data,
        input  data_request
    );
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core
// Asynchronous serial transmitter. It pops words from a FWFT TX FIFO and sends
// each one as a frame: start bit, 5..9 data bits LSB first, optional parity, then
// 1 or 2 stop bits. Bit timing is OVS brgen rising edges (ticks) per bit. The
// block also supports break generation and back-to-back frames.
// Ports:
//   clk, reset : system clock, synchronous active-low reset
//   brgen      : baud-rate-generator output; each rising edge is one tick
//   enable     : low forces the transmitter idle and aborts any frame in flight
//   size       : data bit count minus 5 (clamped to 4, then capped at DATA_W)
//   parity     : 000 none, 001 even, 010 odd, 011 mark, 100 space
//   stop2      : 1 selects two stop bits
//   break_req  : hold the line low
//   fifo       : FIFO handshake (fifo_empty, data, data_request)
//   out        : serial line
//   busy       : high while not IDLE
//   tx_done    : one-clk pulse at the end of a frame's final stop bit
module uart_tx_core #(
    parameter int DATA_W = 9,
    parameter int OVS    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 brgen,
    input  logic                 enable,
    input  logic [2:0]           size,
    input  logic [2:0]           parity,
    input  logic                 stop2,
    input  logic                 break_req,
    uart_tx_core_if.master       fifo,
    output logic                 out,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int         CNT_W = $clog2(OVS);
    localparam logic [3:0] N_MAX = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state;
    logic               brgen_q;
    logic [CNT_W-1:0]   tick_cnt;
    logic [3:0]         bit_cnt;
    logic               stop_cnt;
    logic [DATA_W-1:0]  shift_reg;
    logic [3:0]         n_q;
    logic               has_par_q;
    logic               par_q;
    logic               stop2_q;
    logic               brk_stop_q;   // current STOP period follows a break

    logic               tick;
    logic               last_tick;
    logic               stop_done;
    logic               start_ok;
    logic               do_pop;
    logic               frame_end;
    logic [2:0]         size_eff;
    logic [3:0]         n_sel;
    logic               par_xor;
    logic               has_par;
    logic               par_val;

    assign tick      = brgen & ~brgen_q;
    assign last_tick = (tick_cnt == CNT_W'(OVS - 1));
    assign stop_done = stop_cnt | ~stop2_q;
    assign start_ok  = ~fifo.fifo_empty & ~break_req;
    assign frame_end = (state == S_STOP) && last_tick && stop_done;
    // A pop happens from IDLE, or at the end of a stop period so that the next
    // frame's start bit follows the stop bit with no idle gap.
    assign do_pop    = tick && start_ok && ((state == S_IDLE) || frame_end);

    // Frame configuration and parity of the head word, latched on pop.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path
        // through this block can leave a latch behind.
        size_eff = (size > 3'd4) ? 3'd4 : size;
        n_sel    = {1'b0, size_eff} + 4'd5;
        if (n_sel > N_MAX) begin
            n_sel = N_MAX;
        end
        par_xor = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(n_sel)) begin
                par_xor = par_xor ^ fifo.data[i];
            end
        end
        has_par = 1'b0;
        par_val = 1'b0;
        case (parity)
            3'b001:  begin has_par = 1'b1; par_val = par_xor;  end
            3'b010:  begin has_par = 1'b1; par_val = ~par_xor; end
            3'b011:  begin has_par = 1'b1; par_val = 1'b1;     end
            3'b100:  begin has_par = 1'b1; par_val = 1'b0;     end
            default: begin has_par = 1'b0; par_val = 1'b0;     end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every branch reads the
        // pre-edge register values and later assignments simply override earlier ones.
        if (!reset) begin
            brgen_q           <= 1'b0;
            state             <= S_IDLE;
            tick_cnt          <= '0;
            bit_cnt           <= '0;
            stop_cnt          <= 1'b0;
            shift_reg         <= '0;
            n_q               <= '0;
            has_par_q         <= 1'b0;
            par_q             <= 1'b0;
            stop2_q           <= 1'b0;
            brk_stop_q        <= 1'b0;
            out               <= 1'b1;
            busy              <= 1'b0;
            tx_done           <= 1'b0;
            fifo.data_request <= 1'b0;
        end else begin
            brgen_q           <= brgen;
            tx_done           <= 1'b0;
            fifo.data_request <= 1'b0;
            if (!enable) begin
                // Abort: the popped word, if any, is discarded.
                state    <= S_IDLE;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                out      <= 1'b1;
                busy     <= 1'b0;
            end else if (tick) begin
                if (state != S_IDLE && state != S_BREAK) begin
                    tick_cnt <= last_tick ? '0 : tick_cnt + CNT_W'(1);
                end
                if (frame_end) begin
                    tx_done <= ~brk_stop_q;
                end
                if (do_pop) begin
                    state             <= S_START;
                    shift_reg         <= fifo.data;
                    n_q               <= n_sel;
                    has_par_q         <= has_par;
                    par_q             <= par_val;
                    stop2_q           <= stop2;
                    brk_stop_q        <= 1'b0;
                    fifo.data_request <= 1'b1;
                    tick_cnt          <= '0;
                    out               <= 1'b0;
                    busy              <= 1'b1;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (break_req) begin
                                state    <= S_BREAK;
                                tick_cnt <= '0;
                                out      <= 1'b0;
                                busy     <= 1'b1;
                            end
                        end
                        S_START: begin
                            if (last_tick) begin
                                state   <= S_DATA;
                                bit_cnt <= '0;
                                out     <= shift_reg[0];
                            end
                        end
                        S_DATA: begin
                            if (last_tick) begin
                                if (bit_cnt == n_q - 4'd1) begin
                                    if (has_par_q) begin
                                        state <= S_PARITY;
                                        out   <= par_q;
                                    end else begin
                                        state    <= S_STOP;
                                        stop_cnt <= 1'b0;
                                        out      <= 1'b1;
                                    end
                                end else begin
                                    shift_reg <= shift_reg >> 1;
                                    bit_cnt   <= bit_cnt + 4'd1;
                                    out       <= shift_reg[1];
                                end
                            end
                        end
                        S_PARITY: begin
                            if (last_tick) begin
                                state    <= S_STOP;
                                stop_cnt <= 1'b0;
                                out      <= 1'b1;
                            end
                        end
                        S_STOP: begin
                            if (last_tick) begin
                                if (!stop_done) begin
                                    stop_cnt <= 1'b1;
                                end else begin
                                    state <= S_IDLE;
                                    out   <= 1'b1;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                        S_BREAK: begin
                            // A single forced stop bit guarantees a mark period
                            // before the next start bit.
                            if (!break_req) begin
                                state      <= S_STOP;
                                stop2_q    <= 1'b0;
                                stop_cnt   <= 1'b0;
                                brk_stop_q <= 1'b1;
                                tick_cnt   <= '0;
                                out        <= 1'b1;
                            end
                        end
                        default: begin
                            state <= S_IDLE;
                            out   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core
// Directed bench for uart_tx_core. A queue models the FWFT TX FIFO, brgen gives
// one rising edge every 4 clks, and each tick's outputs are logged into a trace
// (one entry per tick, sampled on the falling clk edge after the tick). Frames are
// then compared bit by bit against hand-built expected frames.
module tb_uart_tx_core;
    localparam int DATA_W = 9;
    localparam int OVS    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       brgen = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] size = 3'd3;
    logic [2:0] parity = 3'd0;
    logic       stop2 = 1'b0;
    logic       break_req = 1'b0;
    logic       out;
    logic       busy;
    logic       tx_done;

    uart_tx_core_if #(.DATA_W(DATA_W)) fifo_if ();

    uart_tx_core #(.DATA_W(DATA_W), .OVS(OVS)) dut (
        .clk       (clk),
        .reset     (reset),
        .brgen     (brgen),
        .enable    (enable),
        .size      (size),
        .parity    (parity),
        .stop2     (stop2),
        .break_req (break_req),
        .fifo      (fifo_if),
        .out       (out),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic o;
        logic r;
        logic d;
        logic b;
    } samp_t;

    samp_t             trace[$];
    logic [DATA_W-1:0] fifo_q[$];
    int                pop_count = 0;
    bit                brgen_run = 1'b0;
    int                brg_ph = 3;
    int                n_checks = 0;
    int                n_pass = 0;

    // FIFO model, tick sampling and brgen generation.
    always @(negedge clk) begin
        samp_t s;
        if (brgen_run && brg_ph == 0) begin
            s.o = out;
            s.r = fifo_if.data_request;
            s.d = tx_done;
            s.b = busy;
            trace.push_back(s);
        end
        if (fifo_if.data_request === 1'b1 && fifo_q.size() > 0) begin
            fifo_q.delete(0);
            pop_count++;
        end
        fifo_if.fifo_empty = (fifo_q.size() == 0);
        fifo_if.data       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        if (brgen_run) brg_ph = (brg_ph + 1) % 4;
        else           brg_ph = 3;
        brgen = brgen_run && (brg_ph <= 1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic field(input samp_t s, input int which);
        case (which)
            0:       return s.o;
            1:       return s.r;
            2:       return s.d;
            default: return s.b;
        endcase
    endfunction

    function automatic int find_first(input int from, input int which, input logic val);
        for (int i = (from < 0 ? 0 : from); i < trace.size(); i++)
            if (field(trace[i], which) === val) return i;
        return -1;
    endfunction

    function automatic int count_val(input int lo, input int hi, input int which, input logic val);
        int n = 0;
        for (int i = (lo < 0 ? 0 : lo); i <= hi && i < trace.size(); i++)
            if (field(trace[i], which) === val) n++;
        return n;
    endfunction

    task automatic wait_trace(input int n, input string tag);
        int t = 0;
        while (trace.size() < n && t < 6000) begin
            @(posedge clk); #1;
            t++;
        end
        if (trace.size() < n) check({tag, " timeout"}, trace.size(), n);
    endtask

    task automatic wait_done(input int from, input int n, input string tag);
        int t = 0;
        while (count_val(from, trace.size() - 1, 2, 1'b1) < n && t < 8000) begin
            @(posedge clk); #1;
            t++;
        end
        if (count_val(from, trace.size() - 1, 2, 1'b1) < n)
            check({tag, " timeout"}, count_val(from, trace.size() - 1, 2, 1'b1), n);
    endtask

    // exp[j] is the j-th transmitted bit (bit 0 = start bit).
    task automatic check_frame(input string tag, input int s, input logic [15:0] exp, input int nbits);
        for (int j = 0; j < nbits; j++) begin
            int          base;
            logic [31:0] obs;
            base = s + j * OVS;
            if (s < 0 || base + OVS > trace.size()) begin
                obs = 32'd3;
            end else begin
                obs = {31'b0, trace[base].o};
                for (int k = 1; k < OVS; k++)
                    if (trace[base + k].o !== trace[base].o) obs = 32'd2;
            end
            check($sformatf("%s bit%0d", tag, j), obs, {31'b0, exp[j]});
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        @(posedge clk); #1;
        fifo_q.push_back(w);
    endtask

    initial begin
        int from, s, d, b, r0, r1, pops0;

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("rst out", out, 1);
        check("rst busy", busy, 0);
        check("rst data_request", fifo_if.data_request, 0);
        check("rst tx_done", tx_done, 0);
        reset = 1'b1;
        enable = 1'b1;
        brgen_run = 1'b1;
        wait_trace(6, "idle");
        check("idle out", count_val(0, 5, 0, 1'b1), 6);
        check("idle no pop", count_val(0, 5, 1, 1'b1), 0);

        // 8N1, 0xA5
        size = 3'd3; parity = 3'd0; stop2 = 1'b0;
        from = trace.size();
        push_word(9'h0A5);
        wait_done(from, 1, "8n1");
        s = find_first(from, 1, 1'b1);
        d = find_first(from, 2, 1'b1);
        check_frame("8n1", s, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        check("8n1 frame length", d - s, 160);
        check("8n1 pop count", count_val(from, trace.size() - 1, 1, 1'b1), 1);
        check("8n1 busy low samples", count_val(s, s + 159, 3, 1'b0), 0);
        wait_trace(trace.size() + 4, "gap");

        // 7E2, 0x55: four ones -> even parity bit 0
        size = 3'd2; parity = 3'd1; stop2 = 1'b1;
        from = trace.size();
        push_word(9'h055);
        wait_done(from, 1, "7e2");
        s = find_first(from, 1, 1'b1);
        d = find_first(from, 2, 1'b1);
        check_frame("7e2", s, {5'b0, 2'b11, 1'b0, 7'h55, 1'b0}, 11);
        check("7e2 frame length", d - s, 176);
        wait_trace(trace.size() + 4, "gap");

        // size=7 clamps to 9 bits; 0x1FF has nine ones -> odd parity bit 0
        size = 3'd7; parity = 3'd2; stop2 = 1'b0;
        from = trace.size();
        push_word(9'h1FF);
        wait_done(from, 1, "9o1");
        s = find_first(from, 1, 1'b1);
        d = find_first(from, 2, 1'b1);
        check_frame("9o1", s, {4'b0, 1'b1, 1'b0, 9'h1FF, 1'b0}, 12);
        check("9o1 frame length", d - s, 192);
        wait_trace(trace.size() + 4, "gap");

        // Mark parity, same word
        parity = 3'd3;
        from = trace.size();
        push_word(9'h1FF);
        wait_done(from, 1, "9m1");
        s = find_first(from, 1, 1'b1);
        d = find_first(from, 2, 1'b1);
        check_frame("9m1", s, {4'b0, 1'b1, 1'b1, 9'h1FF, 1'b0}, 12);
        check("9m1 frame length", d - s, 192);
        wait_trace(trace.size() + 4, "gap");

        // Back-to-back 0x00, 0xFF in 8N1
        size = 3'd3; parity = 3'd0; stop2 = 1'b0;
        from = trace.size();
        @(posedge clk); #1;
        fifo_q.push_back(9'h000);
        fifo_q.push_back(9'h0FF);
        wait_done(from, 2, "b2b");
        r0 = find_first(from, 1, 1'b1);
        r1 = find_first(r0 + 1, 1, 1'b1);
        d  = find_first(from, 2, 1'b1);
        check("b2b pop spacing", r1 - r0, 160);
        check("b2b done meets next pop", d - r1, 0);
        check("b2b done count", count_val(from, trace.size() - 1, 2, 1'b1), 2);
        check("b2b pop count", count_val(from, trace.size() - 1, 1, 1'b1), 2);
        check_frame("b2b f0", r0, {6'b0, 1'b1, 8'h00, 1'b0}, 10);
        check_frame("b2b f1", r1, {6'b0, 1'b1, 8'hFF, 1'b0}, 10);
        wait_trace(trace.size() + 4, "gap");

        // Break with a pending word, then a mid-frame config change
        from = trace.size();
        @(posedge clk); #1;
        break_req = 1'b1;
        fifo_q.push_back(9'h03C);
        wait_trace(from + 4, "brk start");
        b = find_first(from, 0, 1'b0);
        wait_trace(b + 40, "brk hold");
        break_req = 1'b0;
        wait_trace(b + 60, "brk pop");
        s = find_first(b, 1, 1'b1);
        wait_trace(s + 20, "brk cfg");
        size = 3'd0; parity = 3'd1; stop2 = 1'b1;
        wait_done(from, 1, "brk frame");
        d = find_first(from, 2, 1'b1);
        check("brk low ticks", count_val(b, b + 39, 0, 1'b0), 40);
        check("brk mark ticks", count_val(b + 40, b + 55, 0, 1'b1), 16);
        check("brk pop offset", s - b, 56);
        check("brk no tx_done", count_val(from, s, 2, 1'b1), 0);
        check_frame("brk frame", s, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        check("brk frame length", d - s, 160);
        size = 3'd3; parity = 3'd0; stop2 = 1'b0;
        wait_trace(trace.size() + 4, "gap");

        // Abort during data bit 3, then resume with the next word
        from = trace.size();
        pops0 = pop_count;
        @(posedge clk); #1;
        fifo_q.push_back(9'h05A);
        fifo_q.push_back(9'h033);
        wait_trace(from + 20, "abort pop");
        s = find_first(from, 1, 1'b1);
        wait_trace(s + 72, "abort bit3");
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort out", out, 1);
        check("abort busy", busy, 0);
        check("abort data_request", fifo_if.data_request, 0);
        repeat (40) @(posedge clk);
        #1;
        check("abort pop count", pop_count - pops0, 1);
        check("abort no tx_done", count_val(from, trace.size() - 1, 2, 1'b1), 0);
        from = trace.size();
        enable = 1'b1;
        wait_done(from, 1, "resume");
        s = find_first(from, 1, 1'b1);
        d = find_first(from, 2, 1'b1);
        check_frame("resume", s, {6'b0, 1'b1, 8'h33, 1'b0}, 10);
        check("resume frame length", d - s, 160);
        check("resume pop count", pop_count - pops0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
